// File: rtl/iguana_pkg.sv
// Shared types and default HyperBus configuration table for the Iguana SoC.
// IGUANA_HYPCFG_READBACK_EN adds the READ state to the sequencer state type.
package iguana_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } hyp_cfg_entry_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_WRITE,
`ifdef IGUANA_HYPCFG_READBACK_EN
    ST_READ,
`endif
    ST_DONE,
    ST_DRAIN
  } hypcfg_state_e;

  localparam int unsigned HypCfgNumEntries = 4;
  localparam int unsigned HypCfgWaitCycles = 100;

  // Entry 0 is the rightmost element; latency and timing registers of the controller.
  localparam hyp_cfg_entry_t [HypCfgNumEntries-1:0] HypCfgTable = {
    {32'h0000_001C, 32'h0000_0001},
    {32'h0000_0010, 32'h0000_0003},
    {32'h0000_0008, 32'h0000_0006},
    {32'h0000_0004, 32'h0000_0006}
  };

endpackage

// File: rtl/iguana_hyper_cfg_seq.sv
// Post-reset HyperBus configuration sequencer and register-bus arbiter.
// IGUANA_HYPCFG_READBACK_EN: verify each written entry with a read before advancing.
module iguana_hyper_cfg_seq
  import iguana_pkg::*;
#(
  parameter int unsigned NumEntries = HypCfgNumEntries,
  parameter hyp_cfg_entry_t [((NumEntries > 0) ? NumEntries : 1)-1:0] CfgTable = HypCfgTable,
  parameter int unsigned WaitCycles = HypCfgWaitCycles
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     restart_i,
  input  reg_req_t reg_slv_req_i,
  output reg_rsp_t reg_slv_rsp_o,
  output reg_req_t reg_mst_req_o,
  input  reg_rsp_t reg_mst_rsp_i,
  output logic     busy_o,
  output logic     done_o,
  output logic     err_o
);

  localparam int unsigned NE   = (NumEntries > 0) ? NumEntries : 1;
  localparam int unsigned CntW = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;
  localparam int unsigned IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(WaitCycles);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NE - 1);

  hypcfg_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            err_q, err_d;
  logic            done_q, busy_q;
  logic            restart;
  hyp_cfg_entry_t  entry;

  // Constant table mux; a loop keeps the index width independent of NE.
  always_comb begin
    entry = '0;
    for (int i = 0; i < NE; i++) begin
      if (idx_q == IdxW'(i)) entry = CfgTable[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    err_d         = err_q;
    restart       = 1'b0;
    reg_mst_req_o = '0;
    reg_slv_rsp_o = '0;
    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = (NumEntries > 0) ? ST_WRITE : ST_DONE;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      ST_WRITE: begin
        reg_mst_req_o.valid = 1'b1;
        reg_mst_req_o.write = 1'b1;
        reg_mst_req_o.wstrb = '1;
        reg_mst_req_o.addr  = entry.addr;
        reg_mst_req_o.wdata = entry.data;
        if (reg_mst_rsp_i.ready) begin
          if (reg_mst_rsp_i.error) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
`ifdef IGUANA_HYPCFG_READBACK_EN
          else state_d = ST_READ;
`else
          else if (idx_q == LastIdx) state_d = ST_DONE;
          else                       idx_d   = idx_q + IdxW'(1);
`endif
        end
      end
`ifdef IGUANA_HYPCFG_READBACK_EN
      ST_READ: begin
        reg_mst_req_o.valid = 1'b1;
        reg_mst_req_o.addr  = entry.addr;
        if (reg_mst_rsp_i.ready) begin
          if (reg_mst_rsp_i.error || (reg_mst_rsp_i.rdata != entry.data)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (idx_q == LastIdx) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = ST_WRITE;
          end
        end
      end
`endif
      ST_DONE: begin
        reg_mst_req_o = reg_slv_req_i;
        reg_slv_rsp_o = reg_mst_rsp_i;
        // Never cut an in-flight SoC transfer: finish it in DRAIN first.
        if (restart_i) begin
          if (reg_slv_req_i.valid) state_d = ST_DRAIN;
          else                     restart = 1'b1;
        end
      end
      ST_DRAIN: begin
        reg_mst_req_o = reg_slv_req_i;
        reg_slv_rsp_o = reg_mst_rsp_i;
        if (!reg_slv_req_i.valid || reg_mst_rsp_i.ready) restart = 1'b1;
      end
      default: state_d = ST_WAIT;
    endcase
    if (restart) begin
      state_d = ST_WAIT;
      cnt_d   = CntInit;
      idx_d   = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_WAIT;
      cnt_q   <= CntInit;
      idx_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      done_q  <= (state_d == ST_DONE);
      busy_q  <= (state_d != ST_DONE);
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_iguana_hyper_cfg_seq.sv
// Directed bench: power-up sequence with stalled SoC read, write abort,
// restart through DRAIN, and an empty-table/zero-wait instance.
module tb_iguana_hyper_cfg_seq;
  import iguana_pkg::*;

  localparam hyp_cfg_entry_t [2:0] Tbl = {
    {32'h0000_0008, 32'h0000_0007},
    {32'h0000_0004, 32'h0000_0006},
    {32'h0000_0000, 32'h0000_0005}
  };

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     restart = 1'b0;
  reg_req_t slv_req;
  reg_rsp_t slv_rsp;
  reg_req_t mst_req;
  reg_rsp_t mst_rsp;
  logic     busy_o, done_o, err_o;

  logic     hb_ready = 1'b1;
  logic     hb_err_en = 1'b0;
  logic     rb_bad = 1'b0;

  reg_req_t e_slv_req;
  reg_rsp_t e_slv_rsp;
  reg_req_t e_mst_req;
  reg_rsp_t e_mst_rsp;
  logic     e_busy, e_done, e_err;

  int nerr = 0;
  int nchk = 0;
  int wcnt = 0;
  int n8 = 0;
  logic e_seen = 1'b0;

  always #5 clk = ~clk;

  iguana_hyper_cfg_seq #(
    .NumEntries(3), .CfgTable(Tbl), .WaitCycles(4)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .restart_i(restart),
    .reg_slv_req_i(slv_req), .reg_slv_rsp_o(slv_rsp),
    .reg_mst_req_o(mst_req), .reg_mst_rsp_i(mst_rsp),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  iguana_hyper_cfg_seq #(
    .NumEntries(0), .CfgTable(64'h0), .WaitCycles(0)
  ) u_edge (
    .clk_i(clk), .rst_ni(rst_n), .restart_i(1'b0),
    .reg_slv_req_i(e_slv_req), .reg_slv_rsp_o(e_slv_rsp),
    .reg_mst_req_o(e_mst_req), .reg_mst_rsp_i(e_mst_rsp),
    .busy_o(e_busy), .done_o(e_done), .err_o(e_err)
  );

  // HyperBus register model: table addresses read back their data.
  function automatic logic [31:0] hb_rd(input logic [31:0] a);
    case (a)
      32'h0:   hb_rd = 32'h5;
      32'h4:   hb_rd = 32'h6;
      32'h8:   hb_rd = 32'h7;
      default: hb_rd = 32'hCAFE_0000 | a;
    endcase
  endfunction

  always_comb begin
    mst_rsp       = '0;
    mst_rsp.ready = hb_ready;
    mst_rsp.rdata = hb_rd(mst_req.addr);
    mst_rsp.error = hb_err_en && mst_req.valid && mst_req.write && (mst_req.addr == 32'h4);
    if (rb_bad && mst_req.valid && !mst_req.write && (mst_req.addr == 32'h4))
      mst_rsp.rdata = 32'hDEAD_0000;
  end

  always @(posedge clk) begin
    if (mst_req.valid && mst_req.write && mst_rsp.ready && busy_o) wcnt <= wcnt + 1;
    if (mst_req.valid && mst_req.write && (mst_req.addr == 32'h8) && busy_o) n8 <= n8 + 1;
    if (rst_n && e_mst_req.valid) e_seen <= 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns cycles after the current point until done_o is seen, 0 on timeout.
  task automatic wait_done(input int bound, output int cyc);
    cyc = 0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      #1;
      if (done_o) begin
        cyc = c;
        break;
      end
    end
  endtask

  typedef struct {
    logic        soc_vld;
    logic        mvld;
    logic        mwr;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        sready;
    logic [31:0] srdata;
    logic        done;
    logic        busy;
    logic        edone;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int cyc;
    int base;
    slv_req   = '0;
    e_slv_req = '0;
    e_mst_rsp = '0;
    e_mst_rsp.ready = 1'b1;
    e_mst_rsp.rdata = 32'h1234_5678;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0, 32'h5, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h4, 32'h6, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h8, 32'h7, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hCAFE_0010, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hCAFE_0010, 1'b1, 1'b0, 1'b1};

    // Reset values, sampled while reset is held.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.busy",   32'(busy_o),        32'h1);
    chk("rst.done",   32'(done_o),        32'h0);
    chk("rst.err",    32'(err_o),         32'h0);
    chk("rst.mvld",   32'(mst_req.valid), 32'h0);
    chk("rst.sready", 32'(slv_rsp.ready), 32'h0);
    chk("rst.srdata", slv_rsp.rdata,      32'h0);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef IGUANA_HYPCFG_READBACK_EN
    // Power-up with a SoC read to 0x10 held from cycle 1.
    slv_req.addr = 32'h10;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      slv_req.valid = vecs[k].soc_vld;
      #1;
      chk($sformatf("r%0d.mvld", k),   32'(mst_req.valid), 32'(vecs[k].mvld));
      chk($sformatf("r%0d.mwr", k),    32'(mst_req.write), 32'(vecs[k].mwr));
      chk($sformatf("r%0d.maddr", k),  mst_req.addr,       vecs[k].maddr);
      chk($sformatf("r%0d.mwdata", k), mst_req.wdata,      vecs[k].mwdata);
      chk($sformatf("r%0d.sready", k), 32'(slv_rsp.ready), 32'(vecs[k].sready));
      chk($sformatf("r%0d.srdata", k), slv_rsp.rdata,      vecs[k].srdata);
      chk($sformatf("r%0d.done", k),   32'(done_o),        32'(vecs[k].done));
      chk($sformatf("r%0d.busy", k),   32'(busy_o),        32'(vecs[k].busy));
      chk($sformatf("r%0d.err", k),    32'(err_o),         32'h0);
      chk($sformatf("r%0d.edone", k),  32'(e_done),        32'(vecs[k].edone));
    end
    slv_req = '0;

    // Write error on entry 1: abort, entry 2 never issued.
    hb_err_en = 1'b1;
    @(negedge clk);
    do_reset();
    base = n8;
    wait_done(30, cyc);
    chk("werr.done_cyc", 32'(cyc),      32'd7);
    chk("werr.err",      32'(err_o),    32'h1);
    chk("werr.busy",     32'(busy_o),   32'h0);
    chk("werr.entry2",   32'(n8 - base), 32'h0);
    hb_err_en = 1'b0;

    // Restart while a SoC read is stalled by the HyperBus for 3 cycles.
    slv_req.addr  = 32'h10;
    slv_req.valid = 1'b1;
    hb_ready      = 1'b0;
    restart       = 1'b1;
    #1;
    chk("rs.done0", 32'(done_o), 32'h1);
    chk("rs.sready0", 32'(slv_rsp.ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      restart = 1'b0;
      #1;
      chk($sformatf("rs.drain%0d.done", k),  32'(done_o),        32'h0);
      chk($sformatf("rs.drain%0d.busy", k),  32'(busy_o),        32'h1);
      chk($sformatf("rs.drain%0d.mvld", k),  32'(mst_req.valid), 32'h1);
      chk($sformatf("rs.drain%0d.maddr", k), mst_req.addr,       32'h10);
    end
    hb_ready = 1'b1;
    #1;
    chk("rs.sready",  32'(slv_rsp.ready), 32'h1);
    chk("rs.srdata",  slv_rsp.rdata,      32'hCAFE_0010);
    @(negedge clk);
    #1;
    chk("rs.wait.mvld",   32'(mst_req.valid), 32'h0);
    chk("rs.wait.sready", 32'(slv_rsp.ready), 32'h0);
    chk("rs.wait.err",    32'(err_o),         32'h0);
    chk("rs.wait.busy",   32'(busy_o),        32'h1);
    slv_req.valid = 1'b0;
    base = wcnt;
    wait_done(40, cyc);
    chk("rs.done_cyc", 32'(cyc),         32'd8);
    chk("rs.writes",   32'(wcnt - base), 32'd3);
    chk("rs.err",      32'(err_o),       32'h0);
`else
    // Readback of entry 1 returns 0xDEAD0000 instead of 0x00000006.
    rb_bad = 1'b1;
    @(negedge clk);
    do_reset();
    wait_done(40, cyc);
    chk("rb.done_cyc", 32'(cyc),    32'd9);
    chk("rb.err",      32'(err_o),  32'h1);
    chk("rb.busy",     32'(busy_o), 32'h0);
    rb_bad = 1'b0;
`endif

    // Empty table, zero wait: never drove the bus, sits in DONE.
    chk("edge.seen", 32'(e_seen), 32'h0);
    chk("edge.done", 32'(e_done), 32'h1);
    chk("edge.busy", 32'(e_busy), 32'h0);
    chk("edge.err",  32'(e_err),  32'h0);
    chk("edge.sready", 32'(e_slv_rsp.ready), 32'h1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
